mem_rd_cmd_arbiter: RTL and testbench

Shares one memory read channel between NUM_REQ requesters. It sits between the requester-side `axis_mem_cmd`/`axi_stream` pairs and the single DMA/DDR read port. Read commands are arbitrated round-robin onto the shared command port, and a tag FIFO records the issuing requester. Each returned data packet is steered back to that requester in command order, one packet per command.

---
 rtl/mem_rd_cmd_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_rd_cmd_arbiter.sv | 580 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_cmd_arbiter.sv
// mem_rd_cmd_arbiter: shares one memory read channel between NUM_REQ requesters.
// Commands are granted round-robin into a single output register. A tag FIFO
// remembers which requester issued each forwarded command, and returned packets
// are steered back to those requesters in command order.
module mem_rd_cmd_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 512,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          aresetn,
  input  logic [NUM_REQ-1:0]            s_cmd_valid,
  output logic [NUM_REQ-1:0]            s_cmd_ready,
  input  logic [NUM_REQ*64-1:0]         s_cmd_address,
  input  logic [NUM_REQ*32-1:0]         s_cmd_length,
  output logic                          m_cmd_valid,
  input  logic                          m_cmd_ready,
  output logic [63:0]                   m_cmd_address,
  output logic [31:0]                   m_cmd_length,
  input  logic                          s_data_valid,
  output logic                          s_data_ready,
  input  logic [DATA_WIDTH-1:0]         s_data_data,
  input  logic [DATA_WIDTH/8-1:0]       s_data_keep,
  input  logic                          s_data_last,
  output logic [NUM_REQ-1:0]            m_data_valid,
  input  logic [NUM_REQ-1:0]            m_data_ready,
  output logic [DATA_WIDTH-1:0]         m_data_data,
  output logic [DATA_WIDTH/8-1:0]       m_data_keep,
  output logic                          m_data_last,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          zero_len_drop
);

  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int AW    = $clog2(TAG_DEPTH);
  localparam int CNT_W = AW + 1;

  logic [TAG_W-1:0] rr_ptr;
  logic [TAG_W-1:0] grant;
  logic             grant_found;
  logic             cmd_free;
  logic             tag_room;
  logic             accept;
  logic             push;
  logic             pop;
  logic [63:0]      acc_addr;
  logic [31:0]      acc_len;

  logic [TAG_W-1:0] tag_mem [TAG_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_empty;

  // Requester index base+off, wrapped into 0..NUM_REQ-1.
  function automatic logic [TAG_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[TAG_W-1:0];
  endfunction

  // Round-robin search: scan from the highest offset down so the requester
  // closest to rr_ptr is the last (and therefore winning) assignment.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (s_cmd_valid[wrap_idx(int'(rr_ptr), k)]) begin
        grant       = wrap_idx(int'(rr_ptr), k);
        grant_found = 1'b1;
      end
    end
  end

  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign cmd_free    = !m_cmd_valid || m_cmd_ready;
  assign tag_room    = outstanding < CNT_W'(TAG_DEPTH);
  assign accept      = grant_found && cmd_free && tag_room;
  assign s_cmd_ready = accept ? (NUM_REQ'(1) << grant) : '0;
  assign acc_addr    = s_cmd_address[int'(grant)*64 +: 64];
  assign acc_len     = s_cmd_length[int'(grant)*32 +: 32];
  assign push        = accept && (acc_len != '0);

  // Data steering: the FIFO head names the requester that owns the current packet.
  assign fifo_empty   = (outstanding == '0);
  assign head_tag     = tag_mem[rd_ptr];
  assign m_data_valid = (s_data_valid && !fifo_empty) ? (NUM_REQ'(1) << head_tag) : '0;
  assign s_data_ready = !fifo_empty && m_data_ready[head_tag];
  assign m_data_data  = s_data_data;
  assign m_data_keep  = s_data_keep;
  assign m_data_last  = s_data_last;
  assign pop          = s_data_valid && s_data_ready && s_data_last;

  // Command output register, round-robin pointer and zero-length drop pulse.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_cmd_valid   <= 1'b0;
      m_cmd_address <= '0;
      m_cmd_length  <= '0;
      rr_ptr        <= '0;
      zero_len_drop <= 1'b0;
    end else begin
      zero_len_drop <= accept && (acc_len == '0);
      if (accept) begin
        rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
      end
      if (push) begin
        m_cmd_valid   <= 1'b1;
        m_cmd_address <= acc_addr;
        m_cmd_length  <= acc_len;
      end else if (m_cmd_ready) begin
        m_cmd_valid <= 1'b0;
      end
    end
  end

  // Tag FIFO pointers and occupancy count; pointers wrap naturally at TAG_DEPTH.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Tag storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_mem_rd_cmd_arbiter.sv
// Testbench for mem_rd_cmd_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbiter.
module tb_mem_rd_cmd_arbiter;

  localparam int N  = 4;
  localparam int DW = 512;
  localparam int TD = 16;
  localparam int CW = 5;

  logic              clk = 1'b0;
  logic              aresetn = 1'b0;
  logic [N-1:0]      s_cmd_valid;
  logic [N-1:0]      s_cmd_ready;
  logic [N*64-1:0]   s_cmd_address;
  logic [N*32-1:0]   s_cmd_length;
  logic              m_cmd_valid;
  logic              m_cmd_ready;
  logic [63:0]       m_cmd_address;
  logic [31:0]       m_cmd_length;
  logic              s_data_valid;
  logic              s_data_ready;
  logic [DW-1:0]     s_data_data;
  logic [DW/8-1:0]   s_data_keep;
  logic              s_data_last;
  logic [N-1:0]      m_data_valid;
  logic [N-1:0]      m_data_ready;
  logic [DW-1:0]     m_data_data;
  logic [DW/8-1:0]   m_data_keep;
  logic              m_data_last;
  logic [CW-1:0]     outstanding;
  logic              zero_len_drop;

  mem_rd_cmd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_address(s_cmd_address), .s_cmd_length(s_cmd_length),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_address(m_cmd_address), .m_cmd_length(m_cmd_length),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready),
    .s_data_data(s_data_data), .s_data_keep(s_data_keep), .s_data_last(s_data_last),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready),
    .m_data_data(m_data_data), .m_data_keep(m_data_keep), .m_data_last(m_data_last),
    .outstanding(outstanding), .zero_len_drop(zero_len_drop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: round-robin pointer, queue of owning requesters,
  // and the contents of the forwarded command slot.
  int          mdl_rr;
  int          mdl_q[$];
  bit          mdl_cv;
  logic [63:0] mdl_ca;
  logic [31:0] mdl_cl;
  bit          mdl_zld;
  logic [N-1:0] exp_cmd_ready;
  logic [N-1:0] exp_dvalid;
  bit           exp_dready;
  int           exp_grant;

  function automatic void model_reset();
    mdl_rr = 0;
    mdl_q.delete();
    mdl_cv = 0;
    mdl_ca = '0;
    mdl_cl = '0;
    mdl_zld = 0;
  endfunction

  function automatic void model_comb();
    exp_grant = -1;
    for (int k = 0; k < N; k++)
      if (exp_grant < 0 && s_cmd_valid[(mdl_rr + k) % N]) exp_grant = (mdl_rr + k) % N;
    exp_cmd_ready = '0;
    if (exp_grant >= 0 && (!mdl_cv || m_cmd_ready) && mdl_q.size() < TD)
      exp_cmd_ready[exp_grant] = 1'b1;
    exp_dvalid = '0;
    exp_dready = 0;
    if (mdl_q.size() > 0) begin
      exp_dready = m_data_ready[mdl_q[0]];
      if (s_data_valid) exp_dvalid[mdl_q[0]] = 1'b1;
    end
  endfunction

  function automatic void model_clock();
    bit          acc;
    bit          loaded;
    logic [31:0] len;
    model_comb();
    acc = (exp_cmd_ready != '0);
    loaded = 0;
    if (s_data_valid && exp_dready && s_data_last) void'(mdl_q.pop_front());
    mdl_zld = 0;
    if (acc) begin
      len = s_cmd_length[exp_grant*32 +: 32];
      mdl_rr = (exp_grant + 1) % N;
      if (len == 0) begin
        mdl_zld = 1;
      end else begin
        mdl_q.push_back(exp_grant);
        mdl_cv = 1;
        mdl_ca = s_cmd_address[exp_grant*64 +: 64];
        mdl_cl = len;
        loaded = 1;
      end
    end
    if (!loaded && m_cmd_ready) mdl_cv = 0;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
    model_comb();
  endtask

  task automatic set_cmd(input int i, input bit v, input logic [63:0] a, input logic [31:0] l);
    s_cmd_valid[i] = v;
    s_cmd_address[i*64 +: 64] = a;
    s_cmd_length[i*32 +: 32] = l;
  endtask

  task automatic idle_inputs();
    s_cmd_valid   = '0;
    s_cmd_address = '0;
    s_cmd_length  = '0;
    m_cmd_ready   = 1'b1;
    s_data_valid  = 1'b0;
    s_data_data   = '0;
    s_data_keep   = '1;
    s_data_last   = 1'b0;
    m_data_ready  = '1;
  endtask

  task automatic drain_all(input string nm);
    int guard;
    s_cmd_valid = '0;
    m_data_ready = '1;
    guard = 0;
    while (mdl_q.size() > 0 && guard < 64) begin
      s_data_valid = 1'b1;
      s_data_last  = 1'b1;
      s_data_data  = rand_data();
      settle();
      n_vec++;
      if (m_data_valid !== exp_dvalid) begin
        n_err++;
        $display("FAIL %s_drain_route: got %b want %b", nm, m_data_valid, exp_dvalid);
      end
      tick();
      guard++;
    end
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    settle();
    n_vec++;
    if (outstanding !== '0 || guard >= 64) begin
      n_err++;
      $display("FAIL %s_drain_empty: outstanding %0d want 0 (guard %0d)", nm, outstanding, guard);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    aresetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    n_vec++;
    if ({m_cmd_valid, m_cmd_address, m_cmd_length, s_cmd_ready, zero_len_drop} !== '0) begin
      n_err++;
      $display("FAIL reset_cmd: valid %b addr %h len %0d rdy %b zld %b want all 0",
               m_cmd_valid, m_cmd_address, m_cmd_length, s_cmd_ready, zero_len_drop);
    end
    n_vec++;
    if ({m_data_valid, s_data_ready, outstanding} !== '0) begin
      n_err++;
      $display("FAIL reset_data: mdv %b sdr %b out %0d want all 0",
               m_data_valid, s_data_ready, outstanding);
    end
    @(posedge clk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic test_single_cmd();
    logic [DW-1:0] d;
    idle_inputs();
    set_cmd(2, 1'b1, 64'h1000, 32'd128);
    settle();
    n_vec++;
    if (s_cmd_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_accept: s_cmd_ready %b want 0100", s_cmd_ready);
    end
    tick();
    set_cmd(2, 1'b0, '0, '0);
    settle();
    n_vec++;
    if ({m_cmd_valid, m_cmd_address, m_cmd_length} !== {1'b1, 64'h1000, 32'd128}) begin
      n_err++;
      $display("FAIL single_mcmd: valid %b addr %h len %0d want 1/1000/128",
               m_cmd_valid, m_cmd_address, m_cmd_length);
    end
    n_vec++;
    if (outstanding !== 5'd1) begin
      n_err++;
      $display("FAIL single_out1: outstanding %0d want 1", outstanding);
    end
    tick();
    d = rand_data();
    s_data_valid = 1'b1;
    s_data_data  = d;
    s_data_last  = 1'b0;
    settle();
    n_vec++;
    if (m_data_valid !== 4'b0100 || s_data_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_beat1: mdv %b sdr %b want 0100/1", m_data_valid, s_data_ready);
    end
    n_vec++;
    if (m_data_data !== d) begin
      n_err++;
      $display("FAIL single_data: got %h want %h", m_data_data, d);
    end
    tick();
    s_data_last = 1'b1;
    settle();
    n_vec++;
    if (m_data_valid !== 4'b0100 || m_data_last !== 1'b1 || outstanding !== 5'd1) begin
      n_err++;
      $display("FAIL single_beat2: mdv %b last %b out %0d want 0100/1/1",
               m_data_valid, m_data_last, outstanding);
    end
    tick();
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    settle();
    n_vec++;
    if (outstanding !== 5'd0) begin
      n_err++;
      $display("FAIL single_out0: outstanding %0d want 0", outstanding);
    end
  endtask

  task automatic test_round_robin();
    int          want;
    logic [63:0] prev_addr;
    idle_inputs();
    want = 3;
    prev_addr = '0;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < N; i++) set_cmd(i, 1'b1, {$urandom, $urandom}, $urandom_range(1, 4096));
      settle();
      n_vec++;
      if (s_cmd_ready !== 4'(1 << want)) begin
        n_err++;
        $display("FAIL rr_grant%0d: s_cmd_ready %b want requester %0d", c, s_cmd_ready, want);
      end
      if (c > 0) begin
        n_vec++;
        if (m_cmd_address !== prev_addr) begin
          n_err++;
          $display("FAIL rr_addr%0d: m_cmd_address %h want %h", c, m_cmd_address, prev_addr);
        end
      end
      prev_addr = s_cmd_address[want*64 +: 64];
      tick();
      want = (want + 1) % N;
    end
    drain_all("rr");
  endtask

  task automatic test_backpressure();
    logic [63:0] a;
    logic [31:0] l;
    logic [63:0] b;
    idle_inputs();
    a = {$urandom, $urandom};
    l = 32'd64;
    m_cmd_ready = 1'b0;
    set_cmd(1, 1'b1, a, l);
    settle();
    n_vec++;
    if (s_cmd_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL bp_first: s_cmd_ready %b want 0010", s_cmd_ready);
    end
    tick();
    set_cmd(1, 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) begin
      set_cmd(0, 1'b1, {$urandom, $urandom}, 32'd32);
      settle();
      n_vec++;
      if ({m_cmd_valid, m_cmd_address, m_cmd_length} !== {1'b1, a, l}) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid %b addr %h len %0d want 1/%h/%0d",
                 c, m_cmd_valid, m_cmd_address, m_cmd_length, a, l);
      end
      n_vec++;
      if (s_cmd_ready !== 4'b0000) begin
        n_err++;
        $display("FAIL bp_stall%0d: s_cmd_ready %b want 0000", c, s_cmd_ready);
      end
      tick();
    end
    m_cmd_ready = 1'b1;
    b = s_cmd_address[63:0];
    settle();
    n_vec++;
    if (s_cmd_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL bp_release: s_cmd_ready %b want 0001", s_cmd_ready);
    end
    tick();
    set_cmd(0, 1'b0, '0, '0);
    settle();
    n_vec++;
    if ({m_cmd_valid, m_cmd_address, m_cmd_length} !== {1'b1, b, 32'd32}) begin
      n_err++;
      $display("FAIL bp_next: valid %b addr %h len %0d want 1/%h/32",
               m_cmd_valid, m_cmd_address, m_cmd_length, b);
    end
    tick();
    drain_all("bp");
  endtask

  task automatic test_full();
    idle_inputs();
    for (int c = 0; c < 40 && mdl_q.size() < TD; c++) begin
      for (int i = 0; i < N; i++) set_cmd(i, 1'b1, {$urandom, $urandom}, $urandom_range(1, 512));
      tick();
    end
    settle();
    n_vec++;
    if (outstanding !== 5'd16) begin
      n_err++;
      $display("FAIL full_count: outstanding %0d want 16", outstanding);
    end
    n_vec++;
    if (s_cmd_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL full_block: s_cmd_ready %b want 0000", s_cmd_ready);
    end
    s_data_valid = 1'b1;
    s_data_last  = 1'b1;
    settle();
    n_vec++;
    if (s_cmd_ready !== 4'b0000 || s_data_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_popcycle: s_cmd_ready %b sdr %b want 0000/1", s_cmd_ready, s_data_ready);
    end
    tick();
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    settle();
    n_vec++;
    if (outstanding !== 5'd15 || s_cmd_ready !== exp_cmd_ready || $countones(s_cmd_ready) != 1) begin
      n_err++;
      $display("FAIL full_reopen: outstanding %0d s_cmd_ready %b want 15/%b",
               outstanding, s_cmd_ready, exp_cmd_ready);
    end
    tick();
    settle();
    n_vec++;
    if (outstanding !== 5'd16) begin
      n_err++;
      $display("FAIL full_refill: outstanding %0d want 16", outstanding);
    end
    drain_all("full");
  endtask

  task automatic test_zero_len_order();
    logic [DW-1:0] d1;
    idle_inputs();
    set_cmd(1, 1'b1, 64'h2000, 32'd0);
    settle();
    n_vec++;
    if (s_cmd_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL zl_accept: s_cmd_ready %b want 0010", s_cmd_ready);
    end
    tick();
    set_cmd(1, 1'b0, '0, '0);
    settle();
    n_vec++;
    if (zero_len_drop !== 1'b1 || m_cmd_valid !== 1'b0 || outstanding !== 5'd0) begin
      n_err++;
      $display("FAIL zl_drop: zld %b mcv %b out %0d want 1/0/0", zero_len_drop, m_cmd_valid, outstanding);
    end
    tick();
    settle();
    n_vec++;
    if (zero_len_drop !== 1'b0) begin
      n_err++;
      $display("FAIL zl_pulse: zld %b want 0", zero_len_drop);
    end
    set_cmd(3, 1'b1, 64'h3000, 32'd64);
    tick();
    set_cmd(3, 1'b0, '0, '0);
    set_cmd(0, 1'b1, 64'h4000, 32'd64);
    tick();
    set_cmd(0, 1'b0, '0, '0);
    d1 = rand_data();
    m_data_ready = 4'b0111;
    s_data_valid = 1'b1;
    s_data_data  = d1;
    s_data_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_vec++;
      if (s_data_ready !== 1'b0 || m_data_valid !== 4'b1000) begin
        n_err++;
        $display("FAIL zl_stall%0d: sdr %b mdv %b want 0/1000", c, s_data_ready, m_data_valid);
      end
      tick();
    end
    m_data_ready = '1;
    settle();
    n_vec++;
    if (s_data_ready !== 1'b1 || m_data_data !== d1) begin
      n_err++;
      $display("FAIL zl_resume: sdr %b data_ok %b want 1/1", s_data_ready, m_data_data === d1);
    end
    tick();
    s_data_last = 1'b1;
    settle();
    n_vec++;
    if (m_data_valid !== 4'b1000) begin
      n_err++;
      $display("FAIL zl_pkt1: mdv %b want 1000", m_data_valid);
    end
    tick();
    s_data_data = rand_data();
    settle();
    n_vec++;
    if (m_data_valid !== 4'b0001) begin
      n_err++;
      $display("FAIL zl_pkt2: mdv %b want 0001", m_data_valid);
    end
    tick();
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    settle();
    n_vec++;
    if (outstanding !== 5'd0) begin
      n_err++;
      $display("FAIL zl_done: outstanding %0d want 0", outstanding);
    end
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++)
        set_cmd(i, 1'($urandom % 2), {$urandom, $urandom},
                ($urandom % 8 == 0) ? 32'd0 : 32'($urandom_range(1, 4096)));
      m_cmd_ready  = ($urandom % 4) != 0;
      s_data_valid = 1'($urandom % 2);
      s_data_last  = ($urandom % 3) == 0;
      s_data_data  = rand_data();
      s_data_keep  = {$urandom, $urandom};
      m_data_ready = 4'($urandom) | 4'($urandom);
      settle();
      n_vec++;
      if (s_cmd_ready !== exp_cmd_ready) begin
        n_err++;
        $display("FAIL rnd_cmdrdy%0d: got %b want %b", c, s_cmd_ready, exp_cmd_ready);
      end
      n_vec++;
      if (m_cmd_valid !== mdl_cv || m_cmd_address !== mdl_ca || m_cmd_length !== mdl_cl) begin
        n_err++;
        $display("FAIL rnd_mcmd%0d: got %b/%h/%0d want %b/%h/%0d", c,
                 m_cmd_valid, m_cmd_address, m_cmd_length, mdl_cv, mdl_ca, mdl_cl);
      end
      n_vec++;
      if (m_data_valid !== exp_dvalid || s_data_ready !== exp_dready) begin
        n_err++;
        $display("FAIL rnd_route%0d: mdv %b sdr %b want %b/%b", c,
                 m_data_valid, s_data_ready, exp_dvalid, exp_dready);
      end
      n_vec++;
      if (outstanding !== CW'(mdl_q.size()) || zero_len_drop !== mdl_zld) begin
        n_err++;
        $display("FAIL rnd_state%0d: out %0d zld %b want %0d/%b", c,
                 outstanding, zero_len_drop, mdl_q.size(), mdl_zld);
      end
      n_vec++;
      if (m_data_data !== s_data_data || m_data_keep !== s_data_keep || m_data_last !== s_data_last) begin
        n_err++;
        $display("FAIL rnd_pass%0d: keep %h last %b want %h/%b", c,
                 m_data_keep, m_data_last, s_data_keep, s_data_last);
      end
      tick();
    end
    s_data_keep = '1;
    m_cmd_ready = 1'b1;
    drain_all("rnd");
  endtask

  task automatic test_mid_reset();
    idle_inputs();
    set_cmd(2, 1'b1, 64'hABCD000, 32'd256);
    tick();
    set_cmd(2, 1'b0, '0, '0);
    s_data_valid = 1'b1;
    s_data_last  = 1'b0;
    s_data_data  = rand_data();
    settle();
    tick();
    s_data_data = rand_data();
    settle();
    aresetn = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({m_cmd_valid, m_cmd_address, m_cmd_length, s_cmd_ready, zero_len_drop} !== '0) begin
      n_err++;
      $display("FAIL mreset_cmd: valid %b addr %h len %0d rdy %b zld %b want all 0",
               m_cmd_valid, m_cmd_address, m_cmd_length, s_cmd_ready, zero_len_drop);
    end
    n_vec++;
    if ({m_data_valid, s_data_ready, outstanding} !== '0) begin
      n_err++;
      $display("FAIL mreset_data: mdv %b sdr %b out %0d want all 0",
               m_data_valid, s_data_ready, outstanding);
    end
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    settle();
    n_vec++;
    if (s_data_ready !== 1'b0 || m_data_valid !== 4'b0000 || outstanding !== 5'd0) begin
      n_err++;
      $display("FAIL mreset_after: sdr %b mdv %b out %0d want 0/0000/0",
               s_data_ready, m_data_valid, outstanding);
    end
    tick();
    settle();
    n_vec++;
    if (s_data_ready !== 1'b0 || outstanding !== 5'd0) begin
      n_err++;
      $display("FAIL mreset_stall: sdr %b out %0d want 0/0", s_data_ready, outstanding);
    end
    s_data_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_cmd();
    test_round_robin();
    test_backpressure();
    test_full();
    test_zero_len_order();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
